// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: OAM DMA state encodings, register address and
// SPR-RAM geometry.
package ppu_pkg;

    localparam logic [2:0] DMA_IDLE  = 3'd0;
    localparam logic [2:0] DMA_HALT  = 3'd1;
    localparam logic [2:0] DMA_ALIGN = 3'd2;
    localparam logic [2:0] DMA_READ  = 3'd3;
    localparam logic [2:0] DMA_WRITE = 3'd4;
    localparam logic [2:0] DMA_DONE  = 3'd5;

    localparam logic [15:0] OAM_DMA_REG = 16'h4014;
    localparam int          OAM_SIZE    = 256;

    // SPR-RAM destination wraps within the 256-byte OAM.
    function automatic logic [7:0] oam_wr_addr(input logic [7:0] base, input logic [7:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: on a $4014 write, halts the CPU and copies XFER_LEN bytes
// from CPU page {page,00} into SPR-RAM starting at the current OAMADDR.
module oam_dma_ctrl
    import ppu_pkg::*;
#(
    parameter int XFER_LEN = OAM_SIZE,
    parameter bit ALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    input  logic [7:0]  oam_base,
    input  logic        cpu_cycle_odd,
    output logic        cpu_halt,
    output logic        mem_rd_req,
    output logic [15:0] mem_rd_addr,
    input  logic        mem_rd_ack,
    input  logic [7:0]  mem_rd_data,
    output logic [7:0]  spram_cpu_addr,
    output logic [7:0]  spram_cpu_data,
    output logic        spram_write_en,
    output logic        dma_busy,
    output logic        dma_done
);

    localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

    logic [2:0] state_q, state_d;
    logic [8:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic [7:0] base_q, base_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        base_d  = base_q;
        data_d  = data_q;
        case (state_q)
            DMA_IDLE: begin
                if (dma_start) begin
                    page_d  = dma_page;
                    base_d  = oam_base;
                    idx_d   = '0;
                    state_d = DMA_HALT;
                end
            end
            DMA_HALT:  state_d = (ALIGN_EN && cpu_cycle_odd) ? DMA_ALIGN : DMA_READ;
            DMA_ALIGN: state_d = DMA_READ;
            DMA_READ: begin
                if (mem_rd_ack) begin
                    data_d  = mem_rd_data;
                    state_d = DMA_WRITE;
                end
            end
            DMA_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DMA_DONE;
                end else begin
                    idx_d   = idx_q + 9'd1;
                    state_d = DMA_READ;
                end
            end
            DMA_DONE: begin
                idx_d   = '0;
                state_d = DMA_IDLE;
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DMA_IDLE;
            idx_q   <= '0;
            page_q  <= '0;
            base_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            base_q  <= base_d;
            data_q  <= data_d;
        end
    end

    // Moore outputs: every strobe is a pure state decode, so reset clears them at once.
    assign dma_busy       = (state_q != DMA_IDLE);
    assign cpu_halt       = (state_q != DMA_IDLE);
    assign mem_rd_req     = (state_q == DMA_READ);
    assign mem_rd_addr    = {page_q, idx_q[7:0]};
    assign spram_write_en = (state_q == DMA_WRITE);
    assign spram_cpu_addr = oam_wr_addr(base_q, idx_q[7:0]);
    assign spram_cpu_data = data_q;
    assign dma_done       = (state_q == DMA_DONE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl: a page-copy reference model checks every
// SPR-RAM write, read addressing, halt coverage and end-to-end latency.
module tb_oam_dma_ctrl;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_start;
    logic [7:0]  dma_page, oam_base;
    logic        cpu_cycle_odd;

    logic        halt_a, req_a, ack_a, we_a, busy_a, done_a;
    logic [15:0] addr_a;
    logic [7:0]  rdata_a, sp_addr_a, sp_data_a;
    logic        halt_b, req_b, ack_b, we_b, busy_b, done_b;
    logic [15:0] addr_b;
    logic [7:0]  rdata_b, sp_addr_b, sp_data_b;

    logic [7:0]  mem [0:65535];

    int total = 0, bad = 0;
    int cyc = 0;
    logic [7:0] exp_page, exp_base;
    int dly_sel, wait_sum, tgt, wcnt;
    bit waiting;
    int nack_a, nwr_a, nwr_b, done_cnt_a, done_cnt_b, done_cyc_a, done_cyc_b;
    bit run_on, halt_bad;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    oam_dma_ctrl #(.XFER_LEN(N), .ALIGN_EN(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .dma_start(dma_start), .dma_page(dma_page),
        .oam_base(oam_base), .cpu_cycle_odd(cpu_cycle_odd), .cpu_halt(halt_a),
        .mem_rd_req(req_a), .mem_rd_addr(addr_a), .mem_rd_ack(ack_a),
        .mem_rd_data(rdata_a), .spram_cpu_addr(sp_addr_a), .spram_cpu_data(sp_data_a),
        .spram_write_en(we_a), .dma_busy(busy_a), .dma_done(done_a)
    );

    oam_dma_ctrl #(.XFER_LEN(N), .ALIGN_EN(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .dma_start(dma_start), .dma_page(dma_page),
        .oam_base(oam_base), .cpu_cycle_odd(cpu_cycle_odd), .cpu_halt(halt_b),
        .mem_rd_req(req_b), .mem_rd_addr(addr_b), .mem_rd_ack(ack_b),
        .mem_rd_data(rdata_b), .spram_cpu_addr(sp_addr_b), .spram_cpu_data(sp_data_b),
        .spram_write_en(we_b), .dma_busy(busy_b), .dma_done(done_b)
    );

    // Instance B always gets a zero-wait memory.
    assign ack_b   = req_b;
    assign rdata_b = mem[addr_b];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder for A plus write/halt/done monitors for both instances.
    always @(negedge clk) begin
        if (rst) begin
            ack_a   = 1'b0;
            waiting = 1'b0;
        end else begin
            if (req_a) begin
                if (!waiting) begin
                    tgt      = (dly_sel < 0) ? int'($urandom_range(0, 3)) : dly_sel;
                    wait_sum += tgt;
                    wcnt     = 0;
                    waiting  = 1'b1;
                end
                chk("rd_addr", addr_a, {exp_page, 8'(nack_a)});
                if (wcnt == tgt) begin
                    ack_a   = 1'b1;
                    rdata_a = mem[addr_a];
                    waiting = 1'b0;
                    nack_a++;
                end else begin
                    ack_a = 1'b0;
                    wcnt++;
                end
            end else begin
                ack_a   = ($urandom_range(0, 3) == 0);
                rdata_a = 8'($urandom);
            end
            if (we_a) begin
                chk("wr_addr_a", sp_addr_a, 8'(exp_base + 8'(nwr_a)));
                chk("wr_data_a", sp_data_a, mem[{exp_page, 8'(nwr_a)}]);
                nwr_a++;
            end
            if (we_b) begin
                chk("wr_addr_b", sp_addr_b, 8'(exp_base + 8'(nwr_b)));
                chk("wr_data_b", sp_data_b, mem[{exp_page, 8'(nwr_b)}]);
                nwr_b++;
            end
            if (run_on && !halt_a) halt_bad = 1'b1;
            if (done_a) begin
                done_cnt_a++;
                done_cyc_a = cyc;
                run_on     = 1'b0;
            end
            if (done_b) begin
                done_cnt_b++;
                done_cyc_b = cyc;
            end
        end
    end

    task automatic run_dma(input logic [7:0] pg, input logic [7:0] bs, input bit odd,
                           input int dly, input bit inject, input bit dstart, input bit abort);
        int  c0, n;
        bit  injd, fin;
        n = 0; injd = 0; fin = 0;
        exp_page = pg; exp_base = bs; dly_sel = dly; wait_sum = 0; waiting = 1'b0;
        nack_a = 0; nwr_a = 0; nwr_b = 0; done_cnt_a = 0; done_cnt_b = 0; halt_bad = 1'b0;
        @(negedge clk); #2;
        dma_start = 1'b1; dma_page = pg; oam_base = bs; cpu_cycle_odd = odd; c0 = cyc;
        @(negedge clk); #2;
        // Scramble the page/base inputs: the transfer must use the latched copies.
        dma_start = 1'b0; dma_page = 8'($urandom); oam_base = 8'($urandom); run_on = 1'b1;
        while (!fin && n < 20000) begin
            @(negedge clk); #2;
            n++;
            if (dma_start) dma_start = 1'b0;
            if (abort && req_a && nack_a == 64) begin
                run_on = 1'b0;
                rst = 1'b1;
                #1;
                chk("rst_async_req", req_a, 0);
                @(negedge clk); #2;
                chk("rst_halt", halt_a, 0);
                chk("rst_req", req_a, 0);
                chk("rst_busy", busy_a, 0);
                chk("rst_done", done_a, 0);
                chk("rst_busy_b", busy_b, 0);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                #2;
                chk("abort_no_done", done_cnt_a, 0);
                chk("abort_idle", busy_a, 0);
                return;
            end
            if (inject && !injd && nwr_a == 128) begin
                dma_start = 1'b1; dma_page = 8'h07; oam_base = 8'h99; injd = 1'b1;
            end
            if (!abort && done_cnt_a > 0 && done_cnt_b > 0) fin = 1'b1;
        end
        if (!fin) begin
            chk("timeout", 0, 1);
            return;
        end
        chk("lat_a", done_cyc_a - c0, 2 + 2 * N + wait_sum + (odd ? 1 : 0));
        chk("lat_b", done_cyc_b - c0, 2 + 2 * N);
        chk("nwr_a", nwr_a, N);
        chk("nwr_b", nwr_b, N);
        chk("nack_a", nack_a, N);
        chk("halt_held", halt_bad, 0);
        chk("done_once_a", done_cnt_a, 1);
        chk("done_once_b", done_cnt_b, 1);
        if (dstart) begin
            // Start during the DONE cycle must not launch a new transfer.
            dma_start = 1'b1; dma_page = 8'h33; oam_base = 8'h44;
            @(negedge clk); #2;
            dma_start = 1'b0;
            chk("dstart_ign", busy_a, 0);
            @(negedge clk); #2;
            chk("dstart_ign2", busy_a, 0);
        end else begin
            @(negedge clk); #2;
            chk("post_busy", busy_a, 0);
            chk("post_halt", halt_a, 0);
        end
    endtask

    initial begin
        rst = 1'b1; dma_start = 1'b0; dma_page = '0; oam_base = '0; cpu_cycle_odd = 1'b0;
        run_on = 1'b0; ack_a = 1'b0; rdata_a = '0; dly_sel = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_halt0", halt_a, 0);
        chk("rst_req0", req_a, 0);
        chk("rst_busy0", busy_a, 0);
        chk("rst_done0", done_a, 0);
        chk("rst_we0", we_a, 0);
        chk("rst_rdaddr0", addr_a, 0);
        chk("rst_spaddr0", sp_addr_a, 0);
        chk("rst_spdata0", sp_data_a, 0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        run_dma(8'h02, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_dma(8'h02, 8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        run_dma(8'h02, 8'hF0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        run_dma(8'h02, 8'h00, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        run_dma(8'h02, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        run_dma(8'h02, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++)
            run_dma(8'($urandom), 8'($urandom), 1'($urandom), -1, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
